// File: rtl/nn_sequencer.sv
// Three-pass MLP control FSM (hidden lo, hidden hi, output); N+2 cycles per pass, done 154 cycles after start.
// No backpressure: start is ignored while busy, and a watchdog aborts a WAIT that never sees neuron_ready.
module nn_sequencer #(
  parameter int N_IN    = 63,
  parameter int N_HID   = 21,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        neuron_ready,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        neuron_start,
  output logic [1:0]  pass,
  output logic [15:0] N,
  output logic [15:0] counter,
  output logic        hreg1_en,
  output logic        hreg2_en,
  output logic        oreg_en
);

  localparam int              WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [15:0]     N_IN_W  = 16'(N_IN);
  localparam logic [15:0]     N_HID_W = 16'(N_HID);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_WAIT, S_LATCH, S_DONE} state_t;

  state_t         state, state_d;
  logic [WDW-1:0] wdog, wdog_d;
  logic [1:0]     pass_d;
  logic [15:0]    n_d, counter_d;
  logic           busy_d, done_d, terr_d, nstart_d, h1_d, h2_d, o_d;

  // Every output is the registered copy of its *_d value, so nothing is combinational from inputs.
  always_comb begin
    state_d   = state;
    wdog_d    = wdog;
    pass_d    = pass;
    n_d       = N;
    counter_d = counter;
    busy_d    = busy;
    terr_d    = timeout_err;
    nstart_d  = 1'b0;
    done_d    = 1'b0;
    h1_d      = 1'b0;
    h2_d      = 1'b0;
    o_d       = 1'b0;
    case (state)
      S_IDLE: begin
        busy_d    = 1'b0;
        pass_d    = 2'd0;
        n_d       = '0;
        counter_d = '0;
        wdog_d    = '0;
        if (start) begin
          state_d   = S_RUN;
          n_d       = N_IN_W;
          counter_d = N_IN_W;
          nstart_d  = 1'b1;
          busy_d    = 1'b1;
          terr_d    = 1'b0;
        end
      end
      S_RUN: begin
        if (counter == 16'd1) begin
          state_d = S_WAIT;
          wdog_d  = '0;
        end else begin
          counter_d = counter - 16'd1;
        end
      end
      S_WAIT: begin
        if (neuron_ready) begin
          state_d = S_LATCH;
          wdog_d  = '0;
          case (pass)
            2'd0:    h1_d = 1'b1;
            2'd1:    h2_d = 1'b1;
            default: o_d  = 1'b1;
          endcase
        end else if (wdog == WD_LAST) begin
          // Abort without any enable or done; flag stays set until the next accepted start.
          state_d   = S_IDLE;
          wdog_d    = '0;
          terr_d    = 1'b1;
          busy_d    = 1'b0;
          pass_d    = 2'd0;
          n_d       = '0;
          counter_d = '0;
        end else begin
          wdog_d = wdog + 1'b1;
        end
      end
      S_LATCH: begin
        case (pass)
          2'd0: begin
            state_d   = S_RUN;
            pass_d    = 2'd1;
            n_d       = N_IN_W;
            counter_d = N_IN_W;
            nstart_d  = 1'b1;
          end
          2'd1: begin
            state_d   = S_RUN;
            pass_d    = 2'd2;
            n_d       = N_HID_W;
            counter_d = N_HID_W;
            nstart_d  = 1'b1;
          end
          default: begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        endcase
      end
      S_DONE: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        pass_d    = 2'd0;
        n_d       = '0;
        counter_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      wdog         <= '0;
      pass         <= 2'd0;
      N            <= '0;
      counter      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      neuron_start <= 1'b0;
      hreg1_en     <= 1'b0;
      hreg2_en     <= 1'b0;
      oreg_en      <= 1'b0;
    end else begin
      state        <= state_d;
      wdog         <= wdog_d;
      pass         <= pass_d;
      N            <= n_d;
      counter      <= counter_d;
      busy         <= busy_d;
      done         <= done_d;
      timeout_err  <= terr_d;
      neuron_start <= nstart_d;
      hreg1_en     <= h1_d;
      hreg2_en     <= h2_d;
      oreg_en      <= o_d;
    end
  end

endmodule

// File: tb/tb_nn_sequencer.sv
// Directed bench for nn_sequencer: cycle numbers are counted from the edge that samples start.
module tb_nn_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        neuron_ready;
  logic        busy, done, timeout_err, neuron_start;
  logic [1:0]  pass;
  logic [15:0] N, counter;
  logic        hreg1_en, hreg2_en, oreg_en;

  nn_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .neuron_ready (neuron_ready),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err),
    .neuron_start (neuron_start),
    .pass         (pass),
    .N            (N),
    .counter      (counter),
    .hreg1_en     (hreg1_en),
    .hreg2_en     (hreg2_en),
    .oreg_en      (oreg_en)
  );

  always #5 clk = ~clk;

  localparam int MAXC = 1300;

  int n_cmp = 0;
  int n_bad = 0;

  int cnt_a [MAXC];
  int pass_a[MAXC];
  int n_a   [MAXC];
  int busy_a[MAXC];
  int terr_a[MAXC];
  int ns_cyc[3];
  int ns_cnt, h1_cnt, h2_cnt, o_cnt, done_cnt;
  int h1_cyc, h2_cyc, o_cyc, done_cyc, to_cyc;
  int zero_cnt, ovl_cnt;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic ready_f(input int mode, input int c);
    case (mode)
      1:       return (c == 69 || c == 139 || c == 167);
      2:       return (c < 100);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic start_f(input int mode, input int c);
    if (mode == 3) return (c == 10 || c == 154);
    return 1'b0;
  endfunction

  task automatic clear_rec();
    for (int i = 0; i < MAXC; i++) begin
      cnt_a[i] = -1; pass_a[i] = -1; n_a[i] = -1; busy_a[i] = -1; terr_a[i] = -1;
    end
    for (int i = 0; i < 3; i++) ns_cyc[i] = -1;
    ns_cnt = 0; h1_cnt = 0; h2_cnt = 0; o_cnt = 0; done_cnt = 0;
    h1_cyc = -1; h2_cyc = -1; o_cyc = -1; done_cyc = -1; to_cyc = -1;
    zero_cnt = 0; ovl_cnt = 0;
  endtask

  task automatic record(input int c);
    if (c < MAXC) begin
      cnt_a[c]  = int'(counter);
      pass_a[c] = int'(pass);
      n_a[c]    = int'(N);
      busy_a[c] = int'(busy);
      terr_a[c] = int'(timeout_err);
    end
    if (neuron_start) begin
      if (ns_cnt < 3) ns_cyc[ns_cnt] = c;
      ns_cnt++;
    end
    if (hreg1_en) begin h1_cnt++; h1_cyc = c; end
    if (hreg2_en) begin h2_cnt++; h2_cyc = c; end
    if (oreg_en)  begin o_cnt++;  o_cyc  = c; end
    if (done)     begin done_cnt++; done_cyc = c; end
    if (timeout_err && to_cyc < 0 && c > 0) to_cyc = c;
    if (busy && counter == 16'd0) zero_cnt++;
    if ((int'(hreg1_en) + int'(hreg2_en) + int'(oreg_en) > 1) ||
        ((hreg1_en || hreg2_en || oreg_en) && neuron_start)) ovl_cnt++;
  endtask

  // Samples cycle 0 (IDLE, start presented), then cycles 1..last after each edge.
  task automatic run_seq(input int mode, input int last);
    clear_rec();
    @(negedge clk);
    record(0);
    start        = 1'b1;
    neuron_ready = ready_f(mode, 0);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      record(c);
      start        = start_f(mode, c);
      neuron_ready = ready_f(mode, c);
    end
    start        = 1'b0;
    neuron_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; neuron_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",   int'(busy), 0);
    check("rst_done",   int'(done), 0);
    check("rst_terr",   int'(timeout_err), 0);
    check("rst_nstart", int'(neuron_start), 0);
    check("rst_cnt",    int'(counter), 0);
    check("rst_n",      int'(N), 0);
    check("rst_pass",   int'(pass), 0);
    check("rst_en",     int'(hreg1_en) + int'(hreg2_en) + int'(oreg_en), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Ready tied high: nominal timeline.
    run_seq(0, 160);
    check("t1_busy0",   busy_a[0], 0);
    check("t1_busy1",   busy_a[1], 1);
    check("t1_ns_cnt",  ns_cnt, 3);
    check("t1_ns0",     ns_cyc[0], 1);
    check("t1_ns1",     ns_cyc[1], 66);
    check("t1_ns2",     ns_cyc[2], 131);
    check("t1_h1",      h1_cyc, 65);
    check("t1_h2",      h2_cyc, 130);
    check("t1_o",       o_cyc, 153);
    check("t1_done",    done_cyc, 154);
    check("t1_done_n",  done_cnt, 1);
    check("t1_en_n",    h1_cnt + h2_cnt + o_cnt, 3);
    check("t1_c1",      cnt_a[1], 63);
    check("t1_c63",     cnt_a[63], 1);
    check("t1_c64",     cnt_a[64], 1);
    check("t1_c66",     cnt_a[66], 63);
    check("t1_c131",    cnt_a[131], 21);
    check("t1_c151",    cnt_a[151], 1);
    check("t1_n1",      n_a[1], 63);
    check("t1_n131",    n_a[131], 21);
    check("t1_p65",     pass_a[65], 0);
    check("t1_p130",    pass_a[130], 1);
    check("t1_p153",    pass_a[153], 2);
    check("t1_busy154", busy_a[154], 1);
    check("t1_busy155", busy_a[155], 0);
    check("t1_zero",    zero_cnt, 0);
    check("t1_ovl",     ovl_cnt, 0);

    // Ready arrives on the sixth WAIT cycle of every pass.
    run_seq(1, 175);
    check("t2_c64",    cnt_a[64], 1);
    check("t2_c69",    cnt_a[69], 1);
    check("t2_h1",     h1_cyc, 70);
    check("t2_h2",     h2_cyc, 140);
    check("t2_o",      o_cyc, 168);
    check("t2_done",   done_cyc, 169);
    check("t2_ns1",    ns_cyc[1], 71);
    check("t2_en_n",   h1_cnt + h2_cnt + o_cnt, 3);
    check("t2_zero",   zero_cnt, 0);

    // Ready stuck low in pass 1: 1024 WAIT cycles (129..1152) then abort.
    run_seq(2, 1160);
    check("t3_h1_n",    h1_cnt, 1);
    check("t3_h2_n",    h2_cnt, 0);
    check("t3_o_n",     o_cnt, 0);
    check("t3_done_n",  done_cnt, 0);
    check("t3_to",      to_cyc, 1153);
    check("t3_busy1152", busy_a[1152], 1);
    check("t3_busy1153", busy_a[1153], 0);
    check("t3_terr1160", terr_a[1160], 1);

    // Next start clears the sticky flag and runs normally.
    run_seq(0, 160);
    check("t3b_terr0",  terr_a[0], 1);
    check("t3b_terr1",  terr_a[1], 0);
    check("t3b_done",   done_cyc, 154);

    // start re-pulsed in pass 0 RUN and during DONE.
    run_seq(3, 160);
    check("t4_ns_cnt",  ns_cnt, 3);
    check("t4_ns2",     ns_cyc[2], 131);
    check("t4_done_n",  done_cnt, 1);
    check("t4_done",    done_cyc, 154);
    check("t4_p131",    pass_a[131], 2);
    check("t4_busy155", busy_a[155], 0);
    check("t4_busy158", busy_a[158], 0);

    // Asynchronous reset mid pass 1, then a clean run.
    @(negedge clk);
    start = 1'b1; neuron_ready = 1'b1;
    for (int c = 1; c <= 99; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("t5_c99",   int'(counter), 30);
    check("t5_p99",   int'(pass), 1);
    #1 rst = 1'b0;
    #1;
    check("t5_busy",  int'(busy), 0);
    check("t5_cnt",   int'(counter), 0);
    check("t5_pass",  int'(pass), 0);
    check("t5_n",     int'(N), 0);
    neuron_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_seq(0, 160);
    check("t5_ns0",   ns_cyc[0], 1);
    check("t5_p1",    pass_a[1], 0);
    check("t5_c1",    cnt_a[1], 63);
    check("t5_done",  done_cyc, 154);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
